dac_iq_interleaver: RTL

Sample buffer and I/Q interleaver between the PLB DAC register interface and the dual 10-bit DAC pins. Accepts 32-bit words, each packing one I and one Q sample, into a FIFO. Drains the FIFO at a programmable sample rate and emits alternating I/Q 10-bit codes with a write strobe and channel select. Handles format conversion, underrun signalling and idle midscale output.

---
 rtl/dac_iq_interleaver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dac_iq_interleaver.sv
// Sample FIFO and I/Q interleaving engine feeding a dual 10-bit DAC.
// Build macro DAC_IQ_UNDERRUN_HOLD_EN: on underrun, repeat the last popped I/Q pair instead of midscale.
module dac_iq_interleaver #(
    parameter int FIFO_DEPTH  = 16,
    parameter int C_DIV_WIDTH = 8
) (
    input  logic                        Bus2IP_Clk,
    input  logic                        Bus2IP_ResetN,
    input  logic [0:31]                 Wr_Data,
    input  logic                        Wr_Valid,
    output logic                        Wr_Ready,
    input  logic                        Ctl_Enable,
    input  logic                        Ctl_Flush,
    input  logic                        Ctl_Format,
    input  logic [0:C_DIV_WIDTH-1]      Ctl_Div,
    input  logic                        Ctl_ClrUnderrun,
    output logic [0:9]                  DAC_Data,
    output logic                        DAC_Wrt,
    output logic                        DAC_Sel,
    output logic [0:$clog2(FIFO_DEPTH)] Fifo_Level,
    output logic                        Underrun
);
    localparam int                     AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]            FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [9:0]             MIDSCALE = 10'h200;
    localparam logic [C_DIV_WIDTH-1:0] DIV_MIN  = C_DIV_WIDTH'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND_I = 2'd1, SEND_Q = 2'd2} state_t;

    state_t                 state;
    logic [31:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            level, level_nxt;
    logic                   push, pop, empty, tick;
    logic [31:0]            rd_word;
    logic [9:0]             i_code, q_code, q_hold;
    logic [C_DIV_WIDTH-1:0] cnt, lim, div_eff;
    logic [1:0]             vld_pipe;
    logic                   unused_bits;
`ifdef DAC_IQ_UNDERRUN_HOLD_EN
    logic [9:0]             last_i, last_q;
`endif

    assign push    = Wr_Valid & Wr_Ready;
    assign empty   = (level == '0);
    assign tick    = (state != IDLE) && (cnt == lim);
    assign pop     = Ctl_Enable & tick & (state == SEND_I) & ~empty;
    assign rd_word = mem[rd_ptr];

    // Top 10 bits of each halfword; two's complement becomes offset binary by flipping the MSB.
    assign i_code      = {rd_word[31] ^ Ctl_Format, rd_word[30:22]};
    assign q_code      = {rd_word[15] ^ Ctl_Format, rd_word[14:6]};
    assign unused_bits = ^{rd_word[21:16], rd_word[5:0]};

    assign div_eff    = (Ctl_Div == '0) ? DIV_MIN : Ctl_Div;
    assign Fifo_Level = level;
    assign DAC_Wrt    = vld_pipe[1];

    always_comb begin
        level_nxt = level;
        if (Ctl_Flush) begin
            level_nxt = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level_nxt = level + 1'b1;
                2'b01:   level_nxt = level - 1'b1;
                default: level_nxt = level;
            endcase
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (push) mem[wr_ptr] <= Wr_Data;
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_ResetN) begin
        if (!Bus2IP_ResetN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            Wr_Ready <= 1'b1;
        end else begin
            level    <= level_nxt;
            Wr_Ready <= (level_nxt != FULL_LVL);
            if (Ctl_Flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Limit is sampled only while idle or at a wrap so a new divider never cuts a period short.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_ResetN) begin
        if (!Bus2IP_ResetN) begin
            cnt <= '0;
            lim <= DIV_MIN;
        end else if (state == IDLE || tick) begin
            cnt <= '0;
            lim <= div_eff;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_ResetN) begin
        if (!Bus2IP_ResetN) begin
            state    <= IDLE;
            DAC_Data <= MIDSCALE;
            DAC_Sel  <= 1'b0;
            q_hold   <= MIDSCALE;
            vld_pipe <= '0;
            Underrun <= 1'b0;
`ifdef DAC_IQ_UNDERRUN_HOLD_EN
            last_i   <= MIDSCALE;
            last_q   <= MIDSCALE;
`endif
        end else begin
            if (Ctl_ClrUnderrun) Underrun <= 1'b0;
            if (!Ctl_Enable) begin
                state    <= IDLE;
                DAC_Data <= MIDSCALE;
                DAC_Sel  <= 1'b0;
                q_hold   <= MIDSCALE;
                vld_pipe <= '0;
            end else begin
                vld_pipe <= {vld_pipe[0], tick};
                unique case (state)
                    IDLE: state <= SEND_I;
                    SEND_I: if (tick) begin
                        DAC_Sel <= 1'b0;
                        state   <= SEND_Q;
                        if (!empty) begin
                            DAC_Data <= i_code;
                            q_hold   <= q_code;
`ifdef DAC_IQ_UNDERRUN_HOLD_EN
                            last_i   <= i_code;
                            last_q   <= q_code;
`endif
                        end else begin
                            Underrun <= 1'b1;
`ifdef DAC_IQ_UNDERRUN_HOLD_EN
                            DAC_Data <= last_i;
                            q_hold   <= last_q;
`else
                            DAC_Data <= MIDSCALE;
                            q_hold   <= MIDSCALE;
`endif
                        end
                    end
                    SEND_Q: if (tick) begin
                        DAC_Data <= q_hold;
                        DAC_Sel  <= 1'b1;
                        state    <= SEND_I;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
